// File: rtl/xy_output_arbiter.sv
// xy_output_arbiter: one router output port. Computes the XY route of the
// five input-buffer head flits, round-robin arbitrates among the heads routed
// to OUT_DIR, pops the winner and drives a registered flit downstream under
// credit-based flow control.
//
// Optional feature: define XY_ARB_STATS_EN to build the saturating stall
// counter; otherwise stall_cnt_o is tied to zero.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   head_flit_i   head flits {L,W,E,S,N}, 16 bits each, N in [15:0]
//   head_valid_i  head valids {L,W,E,S,N}
//   credit_i      downstream freed one slot this cycle
//   pop_req_o     one-hot pop to the winning input buffer (combinational)
//   grant_o       registered copy of last cycle's pop
//   out_flit_o    registered output flit
//   out_valid_o   out_flit_o valid this cycle
//   credit_cnt_o  current credit count
//   credit_err_o  sticky credit overflow flag
//   stall_cnt_o   cycles with pending requests but no credit (saturating)
module xy_output_arbiter #(
    parameter int unsigned OUT_DIR = 0,
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0,
    parameter int unsigned CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] head_flit_i,
    input  logic [4:0]  head_valid_i,
    input  logic        credit_i,
    output logic [4:0]  pop_req_o,
    output logic [4:0]  grant_o,
    output logic [15:0] out_flit_o,
    output logic        out_valid_o,
    output logic [2:0]  credit_cnt_o,
    output logic        credit_err_o,
    output logic [15:0] stall_cnt_o
);

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned FLIT_W    = 16;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned STALL_W   = 16;
    localparam int unsigned PTR_W     = 3;

    localparam logic [PTR_W-1:0] DIR_N = 3'd0;
    localparam logic [PTR_W-1:0] DIR_S = 3'd1;
    localparam logic [PTR_W-1:0] DIR_E = 3'd2;
    localparam logic [PTR_W-1:0] DIR_W = 3'd3;
    localparam logic [PTR_W-1:0] DIR_L = 3'd4;

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
    localparam logic [PTR_W-1:0] OUT_SEL  = PTR_W'(OUT_DIR);

    // XY dimension-order route of one flit
    function automatic logic [PTR_W-1:0] route_dir(input logic [FLIT_W-1:0] flit);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = flit[15:14];
        dy = flit[13:12];
        if (dx > 2'(MY_X))      route_dir = DIR_E;
        else if (dx < 2'(MY_X)) route_dir = DIR_W;
        else if (dy > 2'(MY_Y)) route_dir = DIR_N;
        else if (dy < 2'(MY_Y)) route_dir = DIR_S;
        else                    route_dir = DIR_L;
    endfunction

    logic [FLIT_W-1:0]  heads [NUM_PORTS];
    logic [4:0]         req;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [3:0]         cand;
    logic               send;
    logic [4:0]         win_onehot;

    logic [PTR_W-1:0]   rr_ptr_q,     rr_ptr_d;
    logic [FLIT_W-1:0]  out_flit_q,   out_flit_d;
    logic               out_valid_q,  out_valid_d;
    logic [4:0]         grant_q,      grant_d;
    logic [CNT_W-1:0]   credit_cnt_q, credit_cnt_d;
    logic               credit_err_q, credit_err_d;

    // Per-lane requests; a lane never routes back out of its own direction
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            heads[i] = head_flit_i[i*FLIT_W +: FLIT_W];
            req[i]   = head_valid_i[i] && (route_dir(heads[i]) == OUT_SEL)
                       && (PTR_W'(i) != OUT_SEL);
        end
    end

    // Round-robin pick: first request strictly after rr_ptr_q, wrapping mod 5
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = 4'(rr_ptr_q) + 4'(k);
            if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
            if (!win_found && req[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign send       = win_found && (credit_cnt_q != '0) && !rst;
    assign win_onehot = 5'(1) << win_idx;
    assign pop_req_o  = send ? win_onehot : 5'b0;

    // Next-state for output register, pointer and credit tracking
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        out_flit_d   = out_flit_q;
        out_valid_d  = 1'b0;
        grant_d      = '0;
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;

        if (send) begin
            rr_ptr_d    = win_idx;
            out_flit_d  = heads[win_idx];
            out_valid_d = 1'b1;
            grant_d     = win_onehot;
        end

        // A returned credit with every downstream slot already free is an overflow
        if (credit_i && (credit_cnt_q == CRED_MAX)) credit_err_d = 1'b1;

        if (send && !credit_i) begin
            credit_cnt_d = credit_cnt_q - CNT_W'(1);
        end else if (!send && credit_i && (credit_cnt_q != CRED_MAX)) begin
            credit_cnt_d = credit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= DIR_L;
            out_flit_q   <= '0;
            out_valid_q  <= 1'b0;
            grant_q      <= '0;
            credit_cnt_q <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            out_flit_q   <= out_flit_d;
            out_valid_q  <= out_valid_d;
            grant_q      <= grant_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign out_flit_o   = out_flit_q;
    assign out_valid_o  = out_valid_q;
    assign grant_o      = grant_q;
    assign credit_cnt_o = credit_cnt_q;
    assign credit_err_o = credit_err_q;

`ifdef XY_ARB_STATS_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where traffic is waiting only for credit
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req) && (credit_cnt_q == '0) && (stall_cnt_q != {STALL_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_xy_output_arbiter.sv
// Directed table-driven bench for xy_output_arbiter (OUT_DIR=E, router at (1,1)).
module tb_xy_output_arbiter;

    logic        clk;
    logic        rst;
    logic [79:0] head_flit_i;
    logic [4:0]  head_valid_i;
    logic        credit_i;
    logic [4:0]  pop_req_o;
    logic [4:0]  grant_o;
    logic [15:0] out_flit_o;
    logic        out_valid_o;
    logic [2:0]  credit_cnt_o;
    logic        credit_err_o;
    logic [15:0] stall_cnt_o;

    int total_checks;
    int passed_checks;

    xy_output_arbiter #(
        .OUT_DIR (2),
        .MY_X    (1),
        .MY_Y    (1),
        .CREDITS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .head_flit_i  (head_flit_i),
        .head_valid_i (head_valid_i),
        .credit_i     (credit_i),
        .pop_req_o    (pop_req_o),
        .grant_o      (grant_o),
        .out_flit_o   (out_flit_o),
        .out_valid_o  (out_valid_o),
        .credit_cnt_o (credit_cnt_o),
        .credit_err_o (credit_err_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  valid;
        logic        credit;
        logic [4:0]  pop;     // expected combinationally in the applied cycle
        logic [4:0]  grant;   // remaining fields expected after the edge
        logic [15:0] flit;
        logic        ovalid;
        logic [2:0]  cnt;
        logic        err;
        logic [15:0] stall;   // value when the stats counter is built
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int step, input logic [15:0] act, input logic [15:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    endtask

    // Heads {L,W,E,S,N}; all target dx>1 so all route East. E lane is a U-turn.
    localparam logic [15:0] FN = 16'hC0AB;
    localparam logic [15:0] FS = 16'h8123;
    localparam logic [15:0] FE = 16'hC111;
    localparam logic [15:0] FW = 16'hB456;
    localparam logic [15:0] FL = 16'hE789;

    initial begin
        int sends;
        logic [15:0] exp_stall;
        total_checks  = 0;
        passed_checks = 0;
        rst          = 1'b1;
        credit_i     = 1'b0;
        head_valid_i = '0;
        head_flit_i  = {FL, FW, FE, FS, FN};

        //                rst  valid     cr   pop       grant     flit     ov  cnt  err stall
        vecs.push_back(vec_t'{1'b1, 5'b00000, 1'b0, 5'b00000, 5'b00000, 16'h0000, 1'b0, 3'd4, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b00001, 1'b0, 5'b00001, 5'b00001, FN,       1'b1, 3'd3, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, FN,       1'b0, 3'd3, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b0, 5'b00010, 5'b00010, FS,       1'b1, 3'd2, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b1, 5'b01000, 5'b01000, FW,       1'b1, 3'd2, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b0, 5'b10000, 5'b10000, FL,       1'b1, 3'd1, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b0, 5'b00001, 5'b00001, FN,       1'b1, 3'd0, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b0, 5'b00000, 5'b00000, FN,       1'b0, 3'd0, 1'b0, 16'd1});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b1, 5'b00000, 5'b00000, FN,       1'b0, 3'd1, 1'b0, 16'd2});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b0, 5'b00010, 5'b00010, FS,       1'b1, 3'd0, 1'b0, 16'd2});
        vecs.push_back(vec_t'{1'b0, 5'b11011, 1'b0, 5'b00000, 5'b00000, FS,       1'b0, 3'd0, 1'b0, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, FS,       1'b0, 3'd1, 1'b0, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, FS,       1'b0, 3'd2, 1'b0, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, FS,       1'b0, 3'd3, 1'b0, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, FS,       1'b0, 3'd4, 1'b0, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, FS,       1'b0, 3'd4, 1'b1, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, FS,       1'b0, 3'd4, 1'b1, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b00100, 1'b0, 5'b00000, 5'b00000, FS,       1'b0, 3'd4, 1'b1, 16'd3});
        vecs.push_back(vec_t'{1'b0, 5'b11111, 1'b0, 5'b01000, 5'b01000, FW,       1'b1, 3'd3, 1'b1, 16'd3});
        vecs.push_back(vec_t'{1'b1, 5'b11111, 1'b0, 5'b00000, 5'b00000, 16'h0000, 1'b0, 3'd4, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b10000, 1'b0, 5'b10000, 5'b10000, FL,       1'b1, 3'd3, 1'b0, 16'd0});
        vecs.push_back(vec_t'{1'b0, 5'b10000, 1'b0, 5'b10000, 5'b10000, FL,       1'b1, 3'd2, 1'b0, 16'd0});

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            head_valid_i = vecs[i].valid;
            credit_i     = vecs[i].credit;
            #1;
            check("pop_req", i, 16'(pop_req_o), 16'(vecs[i].pop));
            @(posedge clk);
            #1;
            check("grant",      i, 16'(grant_o),      16'(vecs[i].grant));
            check("out_flit",   i, out_flit_o,        vecs[i].flit);
            check("out_valid",  i, 16'(out_valid_o),  16'(vecs[i].ovalid));
            check("credit_cnt", i, 16'(credit_cnt_o), 16'(vecs[i].cnt));
            check("credit_err", i, 16'(credit_err_o), 16'(vecs[i].err));
`ifdef XY_ARB_STATS_EN
            exp_stall = vecs[i].stall;
`else
            exp_stall = 16'h0;
`endif
            check("stall_cnt", i, stall_cnt_o, exp_stall);
        end

        // Lone N requester with 2 credits left: exactly two sends, then starve
        sends = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst          = 1'b0;
            head_valid_i = 5'b00001;
            credit_i     = 1'b0;
            @(posedge clk);
            #1;
            if (out_valid_o) sends++;
        end
        check("drain_sends", 100, 16'(sends), 16'd2);
        check("drain_cnt",   100, 16'(credit_cnt_o), 16'd0);

        // One credit pulse at zero: no pop that cycle, one send afterwards
        @(negedge clk);
        credit_i = 1'b1;
        #1;
        check("pulse_pop", 101, 16'(pop_req_o), 16'd0);
        @(posedge clk);
        #1;
        check("pulse_ovalid", 101, 16'(out_valid_o), 16'd0);
        sends = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            credit_i = 1'b0;
            @(posedge clk);
            #1;
            if (out_valid_o) sends++;
        end
        check("pulse_sends", 102, 16'(sends), 16'd1);
        check("pulse_cnt",   102, 16'(credit_cnt_o), 16'd0);
        check("pulse_flit",  102, out_flit_o, FN);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
